uart_resp_sender: RTL
=====================

# uart_resp_sender

Response framer and byte sequencer that sits directly upstream of the UART transmitter. It accepts 16-bit response words from the command processor over a valid/ready handshake and buffers them in a small FIFO. Each word goes out as a byte frame (high byte, low byte, optional checksum) through the transmitter's `trmt`/`tx_data`/`tx_done` interface. Only one transmitter byte is in flight at any time.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO depth in words; must be a power of 2, minimum 2.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `resp`  in  16  response word to send
- `send_resp`  in  1  push request; qualified by `resp_rdy`
- `resp_rdy`  out  1  FIFO not full
- `clr_ovfl`  in  1  synchronous clear of `ovfl`
- `ovfl`  out  1  sticky; push attempted while full
- `trmt`  out  1  registered one-cycle start pulse to the transmitter
- `tx_data`  out  8  registered byte to the transmitter; stable while `trmt` is high
- `tx_done`  in  1  transmitter idle/done level (1 at reset, low while a byte is in flight)
- `busy`  out  1  FSM not IDLE, or FIFO not empty
- `frm_cmplt`  out  1  one-cycle pulse when the last byte of a frame finishes

## Operation
- Push: `send_resp && resp_rdy` writes `resp` at the clock edge.
  - `send_resp && !resp_rdy` drops the word and sets `ovfl`.
  - A push while full is dropped even if a pop happens in the same cycle.
  - `clr_ovfl` has priority over a same-cycle set.
- FIFO pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
  - full: MSBs differ and the rest are equal.
  - empty: pointers are equal.
- FSM states:
  - IDLE: if `!empty && tx_done`, pop the head into the frame register, set byte index 0, load `tx_data` ← head[15:8], set `trmt` ← 1, go to ISSUE.
  - ISSUE: `trmt` is high for exactly this cycle and `tx_done` is ignored. Set `trmt` ← 0 and go to WAIT.
  - WAIT: wait for `tx_done == 1`. Then:
    - If the index is the last byte: pulse `frm_cmplt` and go to IDLE.
    - Otherwise: increment the index, load the next byte into `tx_data`, set `trmt` ← 1, go to ISSUE.
- Byte order per frame: index 0 = `resp[15:8]`, index 1 = `resp[7:0]`, index 2 = checksum (only when enabled).
- Checksum = bitwise NOT of the 8-bit wrapping sum of the high and low bytes.
- Frames are never interleaved. The FIFO continues to accept pushes during transmission.

## Timing
- Reset values:
  - `trmt` = 0, `tx_data` = 0x00
  - `resp_rdy` = 1, `ovfl` = 0, `busy` = 0, `frm_cmplt` = 0
  - FIFO empty, FSM in IDLE, byte index = 0
- Latency: a push at edge P into an empty FIFO, with the FSM in IDLE and `tx_done` = 1, gives a pop at edge P+1 and `trmt` high in cycle P+1..P+2 (first `trmt` high one cycle after the push is visible).
- The transmitter drops `tx_done` the cycle after `trmt` is high. ISSUE exists so the stale `tx_done` = 1 is never treated as completion.
- Inter-byte gap: one cycle from `tx_done` rising to `trmt` high.
- Frame-to-frame: IDLE adds one extra cycle before the next pop.
- `frm_cmplt` is asserted in the cycle after WAIT sees the final `tx_done`.
- `tx_done` low in IDLE (transmitter busy from elsewhere): no pop until it returns high.
- Reset mid-frame: the FIFO contents and the partial frame are discarded and `trmt` deasserts immediately. The transmitter shares `rst_n`.

## Configuration
- `UART_RESP_CHKSUM_EN` defined: frames are 3 bytes and the last index is 2.
- Not defined: frames are 2 bytes, the last index is 1, and the checksum logic is absent.
- Handshake and timing are otherwise identical.

## Structure
- Package `uart_resp_pkg`:
  - `resp_state_t` enum (IDLE, ISSUE, WAIT)
  - `BYTES_PER_FRM` constant (2 or 3, selected by the macro)
  - byte-index width constant
- Sub-module `resp_fifo`: parameterized by DEPTH and width 16, with push/pop, full/empty, asynchronous reset of the pointers only.
- FSM, frame register, and checksum live in the top level.

## Test plan
- Single word 0x1234, checksum off, transmitter model in the loop → `tx_data` 0x12 then 0x34, two `trmt` pulses, one `frm_cmplt`, `busy` falls afterwards.
- Same word with `UART_RESP_CHKSUM_EN` → bytes 0x12, 0x34, 0xB9. Word 0xFF01 → checksum 0xFF (sum wraps to 0x00).
- Push 5 words back-to-back with DEPTH=4 while `tx_done` is held low → `resp_rdy` falls after 4 pushes, the 5th is dropped, `ovfl` = 1. `clr_ovfl` clears it. The 4 words then transmit in order.
- Push on the exact cycle of a pop while full → the word is dropped and `ovfl` sets. Pointer wrap is checked over 12 words.
- `tx_done` held high by the model during ISSUE → no double `trmt`. Exactly one pulse per byte, with a gap of at least one cycle.
- Assert `rst_n` low mid-frame after byte 0 → `trmt` = 0, FIFO empty, `busy` = 0. A new word after release sends a full frame from index 0.

Source files
------------

// File: rtl/uart_resp_sender_pkg.sv
// Shared types and frame-size constants for the UART response sender.
// Frame length follows the UART_RESP_CHKSUM_EN macro.
package uart_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } resp_state_t;

`ifdef UART_RESP_CHKSUM_EN
  localparam int BYTES_PER_FRM = 3;
`else
  localparam int BYTES_PER_FRM = 2;
`endif

  localparam int IDX_W = 2;

endpackage

// File: rtl/uart_resp_sender_if.sv
// Command-side and transmitter-side signals of the UART response sender.
// master: command processor plus transmitter; slave: the sender itself.
interface uart_resp_sender_if;
  logic [15:0] resp;
  logic        send_resp;
  logic        resp_rdy;
  logic        clr_ovfl;
  logic        ovfl;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic        frm_cmplt;

  modport master (
    output resp, send_resp, clr_ovfl, tx_done,
    input  resp_rdy, ovfl, trmt, tx_data, busy, frm_cmplt
  );

  modport slave (
    input  resp, send_resp, clr_ovfl, tx_done,
    output resp_rdy, ovfl, trmt, tx_data, busy, frm_cmplt
  );
endinterface

// File: rtl/uart_resp_sender_fifo.sv
// Word FIFO for the response sender; pointers carry one extra wrap bit.
// Only the pointers are reset, storage is left as-is.
module resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/uart_resp_sender.sv
// Frames buffered 16-bit responses into bytes for the UART transmitter.
// Define UART_RESP_CHKSUM_EN to append an inverted-sum checksum byte.
module uart_resp_sender
  import uart_resp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_resp_sender_if.slave bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_FRM - 1);

  resp_state_t      state_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      frame_q;
  logic [7:0]       tx_data_q, nxt_byte;
  logic             trmt_q, frm_cmplt_q, ovfl_q;
  logic [15:0]      head;
  logic             full, empty, push, pop;

  assign push = bus.send_resp && !full;
  assign pop  = (state_q == IDLE) && !empty && bus.tx_done;

  resp_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (bus.resp),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign idx_d = idx_q + 1'b1;

  always_comb begin
    nxt_byte = frame_q[7:0];
    case (idx_d)
      2'd0:    nxt_byte = frame_q[15:8];
      2'd1:    nxt_byte = frame_q[7:0];
`ifdef UART_RESP_CHKSUM_EN
      2'd2:    nxt_byte = ~(frame_q[15:8] + frame_q[7:0]);
`endif
      default: nxt_byte = frame_q[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovfl_q <= 1'b0;
    end else if (bus.clr_ovfl) begin
      ovfl_q <= 1'b0;
    end else if (bus.send_resp && full) begin
      ovfl_q <= 1'b1;
    end
  end

  // ISSUE ignores tx_done: it is still the stale high from before the byte started
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      frame_q     <= '0;
      tx_data_q   <= '0;
      trmt_q      <= 1'b0;
      frm_cmplt_q <= 1'b0;
    end else begin
      trmt_q      <= 1'b0;
      frm_cmplt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!empty && bus.tx_done) begin
            frame_q   <= head;
            idx_q     <= '0;
            tx_data_q <= head[15:8];
            trmt_q    <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.tx_done) begin
            if (idx_q == LAST_IDX) begin
              frm_cmplt_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              idx_q     <= idx_d;
              tx_data_q <= nxt_byte;
              trmt_q    <= 1'b1;
              state_q   <= ISSUE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.resp_rdy  = !full;
  assign bus.ovfl      = ovfl_q;
  assign bus.trmt      = trmt_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.frm_cmplt = frm_cmplt_q;
  assign bus.busy      = (state_q != IDLE) || !empty;
endmodule
